uart_rx: RTL

Serial UART receiver: 8 data bits, LSB first, 1 stop bit, no flow control, 8N1 by default. It oversamples `i_RX_Serial` with the system clock at `CLKS_PER_BIT` clocks per bit and delivers each byte with a one-cycle valid strobe. It is the board-side receive path for bytes sent by the ESP32, pairing with the existing UART transmitter at the same `CLKS_PER_BIT`.

---
 rtl/uart_rx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_dv;
    logic [7:0]      r_byte;
    logic            r_active;
    logic            r_fe;
    logic            w_cnt_run;
    logic            w_shift_en;
    logic            w_stop_en;
    logic            w_bit_tick;
    logic            w_half_tick;

`ifdef UART_RX_PARITY_EN
    logic            r_par_bad;
    logic            r_pe;
    logic            w_par_en;
`endif

    assign w_rx_s      = r_sync2;
    assign w_bit_tick  = (r_cnt == LAST_CNT);
    assign w_half_tick = (r_cnt == HALF_CNT);

    // Two-flop synchronizer for the asynchronous serial line; idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_RX_Serial;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_next     = r_state;
        w_cnt_run  = 1'b0;
        w_shift_en = 1'b0;
        w_stop_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_cnt_run = 1'b1;
                if (w_half_tick) begin
                    // Mid-start-bit check: a line already back high was a glitch
                    w_cnt_run = 1'b0;
                    w_next    = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                w_cnt_run = 1'b1;
                if (w_bit_tick) begin
                    w_cnt_run  = 1'b0;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_next = S_PARITY;
`else
                        w_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_cnt_run = 1'b1;
                if (w_bit_tick) begin
                    w_cnt_run = 1'b0;
                    w_par_en  = 1'b1;
                    w_next    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_cnt_run = 1'b1;
                if (w_bit_tick) begin
                    w_cnt_run = 1'b0;
                    w_stop_en = 1'b1;
                    w_next    = S_CLEANUP;
                end
            end
            S_CLEANUP: begin
                // Hold here through a break so a stuck-low line yields nothing more
                if (w_rx_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bit-period counter and data bit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
        end else begin
            r_cnt <= w_cnt_run ? (r_cnt + CW'(1)) : '0;
            if (r_state == S_IDLE) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // LSB-first shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= 8'h00;
        end else if (w_shift_en) begin
            r_shift[r_bit_idx] <= w_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity check: the parity bit must equal the XOR of the data bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bad <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_par_bad <= 1'b0;
        end else if (w_par_en) begin
            r_par_bad <= w_rx_s ^ (^r_shift);
        end
    end
`endif

    // Registered result strobes and byte latch; framing error wins over parity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dv   <= 1'b0;
            r_fe   <= 1'b0;
            r_byte <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_pe   <= 1'b0;
`endif
        end else begin
            r_dv <= 1'b0;
            r_fe <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe <= 1'b0;
`endif
            if (w_stop_en) begin
                if (!w_rx_s) begin
                    r_fe <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                else if (r_par_bad) begin
                    r_pe <= 1'b1;
                end
`endif
                else begin
                    r_dv   <= 1'b1;
                    r_byte <= r_shift;
                end
            end
        end
    end

    // Activity flag: high once the start bit is confirmed until back in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
        end else begin
            r_active <= (w_next != S_IDLE) && (w_next != S_START);
        end
    end

    assign o_RX_DV     = r_dv;
    assign o_RX_Byte   = r_byte;
    assign o_RX_Active = r_active;
    assign o_Frame_Err = r_fe;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = r_pe;
`else
    assign o_Parity_Err = 1'b0;
`endif

endmodule
